// File: rtl/diff_commit_queue_pkg.sv
// Shared types and helpers for the difftest commit queue.
// Records are stored at the widest supported XLEN and narrowed at the ports.
package diff_pkg;

   localparam int MAX_LANES = 4;
   localparam int MAX_XLEN  = 64;

   typedef logic [2:0] lane_cnt_t;

   typedef struct packed {
      logic [MAX_XLEN-1:0] pc;
      logic [31:0]         instr;
      logic                skip;
      logic                wen;
      logic [7:0]          wdest;
      logic [MAX_XLEN-1:0] wdata;
   } commit_rec_t;

   typedef enum logic [1:0] {
      RUN,
      PEND,
      FIRE,
      DONE
   } trap_state_t;

   function automatic lane_cnt_t popcount(input logic [MAX_LANES-1:0] v);
      lane_cnt_t n;
      n = '0;
      for (int i = 0; i < MAX_LANES; i++) n = n + lane_cnt_t'(v[i]);
      return n;
   endfunction

   // Slot offset of a lane is the number of valid lanes below it.
   function automatic lane_cnt_t compact_idx(input logic [MAX_LANES-1:0] v, input int lane);
      lane_cnt_t n;
      n = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (i < lane) n = n + lane_cnt_t'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/diff_commit_queue_if.sv
// Commit-in, drain-out, trap and counter signals of the difftest commit queue.
interface diff_commit_queue_if #(
   parameter int NUM_LANES = 2,
   parameter int OUT_LANES = 2,
   parameter int XLEN      = 64
);
   logic [NUM_LANES-1:0]      in_valid;
   logic [NUM_LANES*XLEN-1:0] in_pc;
   logic [NUM_LANES*32-1:0]   in_instr;
   logic [NUM_LANES-1:0]      in_skip;
   logic [NUM_LANES-1:0]      in_wen;
   logic [NUM_LANES*8-1:0]    in_wdest;
   logic [NUM_LANES*XLEN-1:0] in_wdata;
   logic                      in_ready;

   logic                      out_en;
   logic [OUT_LANES-1:0]      out_valid;
   logic [OUT_LANES*8-1:0]    out_index;
   logic [OUT_LANES*XLEN-1:0] out_pc;
   logic [OUT_LANES*32-1:0]   out_instr;
   logic [OUT_LANES-1:0]      out_skip;
   logic [OUT_LANES-1:0]      out_wen;
   logic [OUT_LANES*8-1:0]    out_wdest;
   logic [OUT_LANES*XLEN-1:0] out_wdata;

   logic                      trap_req;
   logic [7:0]                trap_code;
   logic                      trap_valid;
   logic [7:0]                trap_code_o;
   logic [63:0]               cycle_cnt;
   logic [63:0]               instr_cnt;
   logic                      overflow_err;

   modport master (
      output in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
      output out_en, trap_req, trap_code,
      input  in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
      input  out_wdest, out_wdata, trap_valid, trap_code_o, cycle_cnt, instr_cnt,
      input  overflow_err
   );

   modport slave (
      input  in_valid, in_pc, in_instr, in_skip, in_wen, in_wdest, in_wdata,
      input  out_en, trap_req, trap_code,
      output in_ready, out_valid, out_index, out_pc, out_instr, out_skip, out_wen,
      output out_wdest, out_wdata, trap_valid, trap_code_o, cycle_cnt, instr_cnt,
      output overflow_err
   );

endinterface

// File: rtl/diff_commit_queue_lane_compactor.sv
// Maps each valid commit lane to its slot offset so holes between lanes vanish.
module diff_lane_compactor
   import diff_pkg::*;
#(
   parameter int NUM_LANES = 2
) (
   input  logic [NUM_LANES-1:0] lane_valid,
   output lane_cnt_t            lane_offset [NUM_LANES],
   output lane_cnt_t            lane_count
);

   logic [MAX_LANES-1:0] valid_ext;

   always_comb begin
      valid_ext  = MAX_LANES'(lane_valid);
      lane_count = popcount(valid_ext);
      for (int i = 0; i < NUM_LANES; i++) lane_offset[i] = compact_idx(valid_ext, i);
   end

endmodule

// File: rtl/diff_commit_queue.sv
// Difftest commit buffer: compacts per-cycle commits into a FIFO, drains them
// as indexed records, keeps cycle/instruction counters and sequences the trap.
module diff_commit_queue
   import diff_pkg::*;
#(
   parameter int NUM_LANES = 2,
   parameter int OUT_LANES = 2,
   parameter int DEPTH     = 8,
   parameter int XLEN      = 64
) (
   input  logic          clock,
   input  logic          resetn,
   diff_commit_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);

   // One extra pointer bit tells a full queue apart from an empty one.
   typedef logic [PTR_W:0] ptr_t;

   commit_rec_t      mem [DEPTH];
   ptr_t             wr_ptr;
   ptr_t             rd_ptr;
   ptr_t             count;
   ptr_t             pop_cnt;
   logic [PTR_W-1:0] wr_slot [NUM_LANES];
   logic [PTR_W-1:0] rd_slot [OUT_LANES];
   lane_cnt_t        lane_offset [NUM_LANES];
   lane_cnt_t        lane_count;
   logic             in_ready_w;
   logic             push_en;
   trap_state_t      state;
   trap_state_t      state_next;
   logic [7:0]       trap_code_q;
   logic [63:0]      cycle_cnt_q;
   logic [63:0]      instr_cnt_q;
   logic             overflow_q;

   diff_lane_compactor #(.NUM_LANES(NUM_LANES)) u_compactor (
      .lane_valid  (bus.in_valid),
      .lane_offset (lane_offset),
      .lane_count  (lane_count)
   );

   // in_ready looks only at the registered count, so a same-cycle pop never admits a push.
   assign count      = wr_ptr - rd_ptr;
   assign in_ready_w = ((ptr_t'(DEPTH) - count) >= ptr_t'(NUM_LANES)) && (state != DONE);
   assign push_en    = in_ready_w && (|bus.in_valid);

   always_comb begin
      pop_cnt = '0;
      if (bus.out_en) pop_cnt = (count < ptr_t'(OUT_LANES)) ? count : ptr_t'(OUT_LANES);
   end

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) wr_slot[i] = wr_ptr[PTR_W-1:0] + PTR_W'(lane_offset[i]);
      for (int j = 0; j < OUT_LANES; j++) rd_slot[j] = rd_ptr[PTR_W-1:0] + PTR_W'(j);
   end

   always_ff @(posedge clock) begin
      if (push_en) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.in_valid[i]) begin
               mem[wr_slot[i]].pc    <= MAX_XLEN'(bus.in_pc[i*XLEN +: XLEN]);
               mem[wr_slot[i]].instr <= bus.in_instr[i*32 +: 32];
               mem[wr_slot[i]].skip  <= bus.in_skip[i];
               mem[wr_slot[i]].wen   <= bus.in_wen[i];
               mem[wr_slot[i]].wdest <= bus.in_wdest[i*8 +: 8];
               mem[wr_slot[i]].wdata <= MAX_XLEN'(bus.in_wdata[i*XLEN +: XLEN]);
            end
         end
      end
   end

   always_comb begin
      bus.out_valid = '0;
      bus.out_index = '0;
      bus.out_pc    = '0;
      bus.out_instr = '0;
      bus.out_skip  = '0;
      bus.out_wen   = '0;
      bus.out_wdest = '0;
      bus.out_wdata = '0;
      for (int i = 0; i < OUT_LANES; i++) begin
         bus.out_index[i*8 +: 8] = 8'(i);
         if (ptr_t'(i) < pop_cnt) begin
            bus.out_valid[i]             = 1'b1;
            bus.out_pc[i*XLEN +: XLEN]   = mem[rd_slot[i]].pc[XLEN-1:0];
            bus.out_instr[i*32 +: 32]    = mem[rd_slot[i]].instr;
            bus.out_skip[i]              = mem[rd_slot[i]].skip;
            bus.out_wen[i]               = mem[rd_slot[i]].wen;
            bus.out_wdest[i*8 +: 8]      = mem[rd_slot[i]].wdest;
            bus.out_wdata[i*XLEN +: XLEN] = mem[rd_slot[i]].wdata[XLEN-1:0];
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         trap_code_q <= '0;
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + ptr_t'(lane_count);
         rd_ptr      <= rd_ptr + pop_cnt;
         cycle_cnt_q <= cycle_cnt_q + 64'd1;
         instr_cnt_q <= instr_cnt_q + 64'(pop_cnt);
         if (!in_ready_w && (|bus.in_valid)) overflow_q <= 1'b1;
         if ((state == RUN) && bus.trap_req) trap_code_q <= bus.trap_code;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= RUN;
      else         state <= state_next;
   end

   // The trap waits until every earlier commit has left the queue.
   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (bus.trap_req) state_next = PEND;
         PEND:    if ((count == '0) && !push_en) state_next = FIRE;
         FIRE:    state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = RUN;
      endcase
   end

   assign bus.in_ready     = in_ready_w;
   assign bus.trap_valid   = (state == FIRE);
   assign bus.trap_code_o  = trap_code_q;
   assign bus.cycle_cnt    = cycle_cnt_q;
   assign bus.instr_cnt    = instr_cnt_q;
   assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_diff_commit_queue.sv
// Self-checking bench for diff_commit_queue with a queue-based reference model.
module tb_diff_commit_queue;

   localparam int NL    = 4;
   localparam int OL    = 2;
   localparam int DEPTH = 8;
   localparam int XLEN  = 64;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        skip;
      logic        wen;
      logic [7:0]  wdest;
      logic [63:0] wdata;
   } ref_rec_t;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   diff_commit_queue_if #(.NUM_LANES(NL), .OUT_LANES(OL), .XLEN(XLEN)) bus ();

   diff_commit_queue #(.NUM_LANES(NL), .OUT_LANES(OL), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int          tests_run    = 0;
   int          tests_failed = 0;
   ref_rec_t    ref_q[$];
   ref_rec_t    lane_rec[NL];
   logic [63:0] ref_cycle;
   logic [63:0] ref_instr;
   logic [7:0]  ref_code;
   bit          ref_ovf;
   bit          trap_latched;
   bit          trap_pulse;
   bit          halted;

   function automatic bit ref_ready();
      return !halted && ((DEPTH - ref_q.size()) >= NL);
   endfunction

   function automatic int ref_pop();
      if (!bus.out_en) return 0;
      return (ref_q.size() < OL) ? ref_q.size() : OL;
   endfunction

   function automatic logic [OL-1:0] ref_valid_vec();
      logic [OL-1:0] r;
      r = '0;
      for (int i = 0; i < ref_pop(); i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic drive_lanes(input logic [NL-1:0] v, input logic [63:0] base);
      for (int i = 0; i < NL; i++) begin
         lane_rec[i].pc    = base + 64'(4 * i);
         lane_rec[i].instr = $urandom;
         lane_rec[i].skip  = 1'($urandom);
         lane_rec[i].wen   = 1'($urandom);
         lane_rec[i].wdest = 8'($urandom);
         lane_rec[i].wdata = {$urandom, $urandom};
         bus.in_pc[i*XLEN +: XLEN]    = lane_rec[i].pc;
         bus.in_instr[i*32 +: 32]     = lane_rec[i].instr;
         bus.in_skip[i]               = lane_rec[i].skip;
         bus.in_wen[i]                = lane_rec[i].wen;
         bus.in_wdest[i*8 +: 8]       = lane_rec[i].wdest;
         bus.in_wdata[i*XLEN +: XLEN] = lane_rec[i].wdata;
      end
      bus.in_valid = v;
   endtask

   // Advances one clock edge and applies the same edge to the reference model.
   task automatic tick();
      int            m;
      int            size_before;
      bit            rdy;
      bit            pushed;
      bit            req;
      logic [7:0]    code;
      logic [NL-1:0] v;
      v           = bus.in_valid;
      req         = bus.trap_req;
      code        = bus.trap_code;
      size_before = ref_q.size();
      m           = ref_pop();
      rdy         = ref_ready();
      pushed      = rdy && (v != '0);
      @(posedge clock);
      repeat (m) void'(ref_q.pop_front());
      ref_instr = ref_instr + 64'(m);
      if (pushed) begin
         for (int i = 0; i < NL; i++) if (v[i]) ref_q.push_back(lane_rec[i]);
      end else if (v != '0) begin
         ref_ovf = 1'b1;
      end
      ref_cycle = ref_cycle + 64'd1;
      if (!trap_latched && req) begin
         trap_latched = 1'b1;
         ref_code     = code;
      end else if (trap_pulse) begin
         trap_pulse = 1'b0;
         halted     = 1'b1;
      end else if (trap_latched && !halted && (size_before == 0) && !pushed) begin
         trap_pulse = 1'b1;
      end
      #1;
   endtask

   task automatic do_reset();
      resetn        = 1'b0;
      bus.out_en    = 1'b0;
      bus.trap_req  = 1'b0;
      bus.trap_code = 8'h00;
      drive_lanes('0, 64'h0);
      ref_q.delete();
      ref_cycle    = '0;
      ref_instr    = '0;
      ref_code     = '0;
      ref_ovf      = 1'b0;
      trap_latched = 1'b0;
      trap_pulse   = 1'b0;
      halted       = 1'b0;
      #1;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++;
      if (bus.out_valid !== '0 || bus.in_ready !== 1'b1 || bus.trap_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags got v=%b rdy=%b trap=%b want v=00 rdy=1 trap=0", bus.out_valid, bus.in_ready, bus.trap_valid);
      end
      tests_run++;
      if (bus.cycle_cnt !== 64'd0 || bus.instr_cnt !== 64'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_counters got cc=%0d ic=%0d want 0 0", bus.cycle_cnt, bus.instr_cnt);
      end
      tests_run++;
      if (bus.trap_code_o !== 8'h00 || bus.overflow_err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_code_ovf got code=%h ovf=%b want 00 0", bus.trap_code_o, bus.overflow_err);
      end
   endtask

   task automatic test_basic_pair();
      bus.out_en = 1'b1;
      drive_lanes(4'b0011, 64'h1c000000);
      #1;
      tick();
      drive_lanes('0, 64'h0);
      #1;
      tests_run++;
      if (bus.out_valid !== 2'b11) begin
         tests_failed++;
         $display("[TB] FAIL pair_valid got %b want 11", bus.out_valid);
      end
      tests_run++;
      if (bus.out_index !== {8'd1, 8'd0}) begin
         tests_failed++;
         $display("[TB] FAIL pair_index got %h want 0100", bus.out_index);
      end
      tests_run++;
      if (bus.out_pc[63:0] !== 64'h1c000000 || bus.out_pc[127:64] !== 64'h1c000004) begin
         tests_failed++;
         $display("[TB] FAIL pair_pc got %h %h want 1c000000 1c000004", bus.out_pc[63:0], bus.out_pc[127:64]);
      end
      tick();
      tests_run++;
      if (bus.instr_cnt !== 64'd2 || bus.out_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL pair_instr_cnt got ic=%0d v=%b want 2 00", bus.instr_cnt, bus.out_valid);
      end
   endtask

   task automatic test_holes();
      logic [63:0] wd_b;
      logic [63:0] wd_d;
      bus.out_en = 1'b1;
      drive_lanes(4'b1010, 64'h0000a000);
      wd_b = lane_rec[1].wdata;
      wd_d = lane_rec[3].wdata;
      #1;
      tick();
      drive_lanes('0, 64'h0);
      #1;
      tests_run++;
      if (bus.out_valid !== 2'b11 || bus.out_pc[63:0] !== 64'ha004 || bus.out_pc[127:64] !== 64'ha00c) begin
         tests_failed++;
         $display("[TB] FAIL holes_pc got v=%b %h %h want 11 a004 a00c", bus.out_valid, bus.out_pc[63:0], bus.out_pc[127:64]);
      end
      tests_run++;
      if (bus.out_wdata[63:0] !== wd_b || bus.out_wdata[127:64] !== wd_d) begin
         tests_failed++;
         $display("[TB] FAIL holes_wdata got %h %h want %h %h", bus.out_wdata[63:0], bus.out_wdata[127:64], wd_b, wd_d);
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [OL-1:0] exp_v;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         drive_lanes(4'b0011, 64'h100 + 64'(8 * c));
         #1;
         tests_run++;
         if (bus.in_ready !== ref_ready() || bus.overflow_err !== ref_ovf) begin
            tests_failed++;
            $display("[TB] FAIL bp_ready push=%0d got rdy=%b ovf=%b want rdy=%b ovf=%b", c, bus.in_ready, bus.overflow_err, ref_ready(), ref_ovf);
         end
         tick();
      end
      drive_lanes('0, 64'h0);
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b0 || bus.overflow_err !== 1'b1 || bus.out_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL bp_full got rdy=%b ovf=%b v=%b want 0 1 00", bus.in_ready, bus.overflow_err, bus.out_valid);
      end
      bus.out_en = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         exp_v = ref_valid_vec();
         tests_run++;
         if (bus.out_valid !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL bp_drain_valid cyc=%0d got %b want %b", c, bus.out_valid, exp_v);
         end
         for (int i = 0; i < OL; i++) begin
            if (exp_v[i]) begin
               tests_run++;
               if (bus.out_pc[i*XLEN +: XLEN] !== ref_q[i].pc) begin
                  tests_failed++;
                  $display("[TB] FAIL bp_drain_pc lane=%0d got %h want %h", i, bus.out_pc[i*XLEN +: XLEN], ref_q[i].pc);
               end
            end
         end
         tick();
      end
      tests_run++;
      if (bus.instr_cnt !== 64'd6 || bus.out_valid !== 2'b00 || bus.overflow_err !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL bp_after got ic=%0d v=%b ovf=%b want 6 00 1", bus.instr_cnt, bus.out_valid, bus.overflow_err);
      end
   endtask

   task automatic test_trap_drain();
      logic [OL-1:0] exp_v;
      int            pulses;
      pulses = 0;
      do_reset();
      drive_lanes(4'b0111, 64'h2000);
      #1;
      tick();
      drive_lanes(4'b0011, 64'h3000);
      bus.trap_req  = 1'b1;
      bus.trap_code = 8'h00;
      #1;
      tick();
      bus.trap_req = 1'b0;
      drive_lanes('0, 64'h0);
      bus.out_en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         exp_v = ref_valid_vec();
         tests_run++;
         if (bus.out_valid !== exp_v || bus.trap_valid !== trap_pulse) begin
            tests_failed++;
            $display("[TB] FAIL trap_seq cyc=%0d got v=%b trap=%b want v=%b trap=%b", c, bus.out_valid, bus.trap_valid, exp_v, trap_pulse);
         end
         for (int i = 0; i < OL; i++) begin
            if (exp_v[i]) begin
               tests_run++;
               if (bus.out_pc[i*XLEN +: XLEN] !== ref_q[i].pc) begin
                  tests_failed++;
                  $display("[TB] FAIL trap_pc lane=%0d got %h want %h", i, bus.out_pc[i*XLEN +: XLEN], ref_q[i].pc);
               end
            end
         end
         if (bus.trap_valid === 1'b1) begin
            pulses++;
            tests_run++;
            if (bus.instr_cnt !== 64'd5) begin
               tests_failed++;
               $display("[TB] FAIL trap_after_drain got ic=%0d want 5", bus.instr_cnt);
            end
         end
         tick();
      end
      tests_run++;
      if (pulses != 1 || bus.in_ready !== 1'b0 || bus.trap_code_o !== 8'h00) begin
         tests_failed++;
         $display("[TB] FAIL trap_done got pulses=%0d rdy=%b code=%h want 1 0 00", pulses, bus.in_ready, bus.trap_code_o);
      end
      drive_lanes(4'b0001, 64'h4000);
      #1;
      tick();
      drive_lanes('0, 64'h0);
      #1;
      tests_run++;
      if (bus.overflow_err !== 1'b1 || bus.out_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL trap_halted_push got ovf=%b v=%b want 1 00", bus.overflow_err, bus.out_valid);
      end
   endtask

   task automatic test_trap_first_code();
      logic [7:0] code1;
      do_reset();
      code1         = 8'($urandom_range(1, 255));
      bus.out_en    = 1'b1;
      bus.trap_req  = 1'b1;
      bus.trap_code = code1;
      #1;
      tick();
      bus.trap_code = ~code1;
      #1;
      tick();
      bus.trap_req = 1'b0;
      #1;
      tests_run++;
      if (bus.trap_valid !== 1'b1 || bus.trap_code_o !== code1) begin
         tests_failed++;
         $display("[TB] FAIL first_code got trap=%b code=%h want 1 %h", bus.trap_valid, bus.trap_code_o, code1);
      end
      tick();
      tests_run++;
      if (bus.trap_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.trap_code_o !== ref_code) begin
         tests_failed++;
         $display("[TB] FAIL first_code_done got trap=%b rdy=%b code=%h want 0 0 %h", bus.trap_valid, bus.in_ready, bus.trap_code_o, ref_code);
      end
   endtask

   task automatic test_pointer_wrap();
      logic [NL-1:0] v;
      logic [OL-1:0] exp_v;
      int            total;
      int            k;
      total = 0;
      do_reset();
      bus.out_en = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (c < 20) begin
            k = (c % 2 == 0) ? 1 : 2;
            do v = 4'($urandom); while ($countones(v) != k);
            total += k;
         end else if (c < 26) begin
            v = '0;
         end else begin
            v          = 4'($urandom);
            bus.out_en = ($urandom_range(0, 3) != 0);
         end
         drive_lanes(v, 64'h80000000 + 64'(16 * c));
         #1;
         exp_v = ref_valid_vec();
         tests_run++;
         if (bus.out_valid !== exp_v || bus.in_ready !== ref_ready() || bus.overflow_err !== ref_ovf ||
             bus.instr_cnt !== ref_instr || bus.cycle_cnt !== ref_cycle) begin
            tests_failed++;
            $display("[TB] FAIL wrap_status cyc=%0d got v=%b rdy=%b ovf=%b ic=%0d cc=%0d want v=%b rdy=%b ovf=%b ic=%0d cc=%0d",
                     c, bus.out_valid, bus.in_ready, bus.overflow_err, bus.instr_cnt, bus.cycle_cnt,
                     exp_v, ref_ready(), ref_ovf, ref_instr, ref_cycle);
         end
         for (int i = 0; i < OL; i++) begin
            if (exp_v[i]) begin
               tests_run++;
               if (bus.out_pc[i*XLEN +: XLEN] !== ref_q[i].pc || bus.out_instr[i*32 +: 32] !== ref_q[i].instr ||
                   bus.out_skip[i] !== ref_q[i].skip || bus.out_wen[i] !== ref_q[i].wen ||
                   bus.out_wdest[i*8 +: 8] !== ref_q[i].wdest || bus.out_wdata[i*XLEN +: XLEN] !== ref_q[i].wdata) begin
                  tests_failed++;
                  $display("[TB] FAIL wrap_rec cyc=%0d lane=%0d got pc=%h wd=%h want pc=%h wd=%h",
                           c, i, bus.out_pc[i*XLEN +: XLEN], bus.out_wdata[i*XLEN +: XLEN], ref_q[i].pc, ref_q[i].wdata);
               end
            end
         end
         tick();
         if (c == 25) begin
            tests_run++;
            if (bus.instr_cnt !== 64'(total)) begin
               tests_failed++;
               $display("[TB] FAIL wrap_total got ic=%0d want %0d", bus.instr_cnt, total);
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      drive_lanes(4'b0011, 64'h5000);
      #1;
      tick();
      drive_lanes(4'b1100, 64'h6000);
      #1;
      tick();
      drive_lanes('0, 64'h0);
      bus.out_en = 1'b1;
      #1;
      tests_run++;
      if (bus.out_valid !== 2'b11 || bus.out_pc[63:0] !== 64'h5000) begin
         tests_failed++;
         $display("[TB] FAIL mid_pre got v=%b pc=%h want 11 5000", bus.out_valid, bus.out_pc[63:0]);
      end
      #2;
      resetn = 1'b0;
      #1;
      tests_run++;
      if (bus.out_valid !== 2'b00 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL mid_async got v=%b rdy=%b want 00 1", bus.out_valid, bus.in_ready);
      end
      do_reset();
      bus.out_en = 1'b1;
      #1;
      tests_run++;
      if (bus.cycle_cnt !== 64'd0 || bus.instr_cnt !== 64'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 2'b00) begin
         tests_failed++;
         $display("[TB] FAIL mid_release got cc=%0d ic=%0d rdy=%b v=%b want 0 0 1 00", bus.cycle_cnt, bus.instr_cnt, bus.in_ready, bus.out_valid);
      end
      drive_lanes(4'b0100, 64'hf000);
      #1;
      tick();
      drive_lanes('0, 64'h0);
      #1;
      tests_run++;
      if (bus.out_valid !== 2'b01 || bus.out_pc[63:0] !== 64'hf008) begin
         tests_failed++;
         $display("[TB] FAIL mid_fresh got v=%b pc=%h want 01 f008", bus.out_valid, bus.out_pc[63:0]);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_pair();
      test_holes();
      test_backpressure();
      test_trap_drain();
      test_trap_first_code();
      test_pointer_wrap();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
